// File: rtl/shared_reg_pkg.sv
// ============================================================================
//  Module   : shared_reg_pkg
//  Purpose  : Shared types and helpers for the shared-register write arbiter.
//             Holds the arbiter FSM state encoding and the requester-index
//             width helper.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package shared_reg_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // Width of a requester index. N_REQ is at least 2, so $clog2 is >= 1.
  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
//  Module   : rr_pick
//  Purpose  : Combinational round-robin finder. Returns the first set bit of
//             req, searching upward from ptr+1 with wrap-around, so the index
//             held in ptr gets the lowest priority.
//  Ports    : req   in  N_REQ  request vector
//             ptr   in  IW     last-served index
//             sel   out IW     chosen index (0 when valid is low)
//             valid out 1      at least one request is set
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [IW-1:0]    sel,
  output logic             valid
);

  // One extra bit so ptr+k (max 2*N_REQ-1) never overflows before wrapping.
  logic [IW:0] w_sum;

  always_comb begin
    sel   = '0;
    valid = 1'b0;
    w_sum = '0;
    // Offsets 1..N_REQ: offset N_REQ revisits ptr itself last, which is what
    // lets a lone persistent requester be granted again.
    for (int k = 1; k <= N_REQ; k++) begin
      w_sum = {1'b0, ptr} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(N_REQ)) begin
        w_sum = w_sum - (IW+1)'(N_REQ);
      end
      if (!valid && req[w_sum[IW-1:0]]) begin
        valid = 1'b1;
        sel   = w_sum[IW-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/shared_reg_arbiter.sv
// ============================================================================
//  Module   : shared_reg_arbiter
//  Purpose  : Round-robin write arbiter in front of one shared WIDTH-bit
//             register. One write per three cycles at most:
//             IDLE (arbitrate) -> WRITE (load q, pulse gnt) -> RELEASE.
//  Ports    : clk    in  1            rising-edge clock
//             rst_n  in  1            asynchronous active-low reset
//             req    in  N_REQ        per-requester write request (level)
//             wdata  in  N_REQ*WIDTH  packed data, requester i at [i*WIDTH +: WIDTH]
//             gnt    out N_REQ        registered one-hot grant pulse
//             q      out WIDTH        stored value
//             nq     out WIDTH        complement of q
//             busy   out 1            FSM not in IDLE
//             q_par  out 1            parity of q (SHARED_REG_PARITY_EN only)
//  Config   : SHARED_REG_PARITY_EN adds the q_par output and its flop.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module shared_reg_arbiter
  import shared_reg_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] wdata,
  output logic [N_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]       q,
  output logic [WIDTH-1:0]       nq,
  output logic                   busy
`ifdef SHARED_REG_PARITY_EN
  ,
  output logic                   q_par
`endif
);

  localparam int c_iw = idx_w(N_REQ);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_iw-1:0]    r_sel;
  logic [c_iw-1:0]    r_ptr;
  logic [WIDTH-1:0]   r_q;
  logic [N_REQ-1:0]   r_gnt;

  logic [c_iw-1:0]    w_pick;
  logic               w_pick_vld;
  logic               w_capture;
  logic               w_write;
  logic               w_req_sel;
  logic [WIDTH-1:0]   w_wsel;
  logic [N_REQ-1:0]   w_onehot;

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (c_iw)
  ) u_pick (
    .req   (req),
    .ptr   (r_ptr),
    .sel   (w_pick),
    .valid (w_pick_vld)
  );

  assign w_req_sel = req[r_sel];
  assign w_wsel    = wdata[int'(r_sel)*WIDTH +: WIDTH];
  assign w_onehot  = N_REQ'(1) << r_sel;

  // Next-state and control strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_write     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_vld) begin
          w_capture   = 1'b1;
          w_state_nxt = WRITE;
        end
      end
      WRITE: begin
        // A request withdrawn between sampling and writing is dropped
        // silently: no write, no grant, pointer untouched.
        if (w_req_sel) begin
          w_write     = 1'b1;
          w_state_nxt = RELEASE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RELEASE: begin
        // req is ignored here so the winner has a cycle to drop it.
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath: selected index, round-robin pointer, storage register, grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel <= '0;
      r_ptr <= c_iw'(N_REQ-1);
      r_q   <= '0;
      r_gnt <= '0;
    end else begin
      if (w_capture) begin
        r_sel <= w_pick;
      end
      if (w_write) begin
        r_q   <= w_wsel;
        r_ptr <= r_sel;
      end
      // Grant is a single-cycle pulse aligned with the new q.
      r_gnt <= w_write ? w_onehot : '0;
    end
  end

`ifdef SHARED_REG_PARITY_EN
  logic r_par;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par <= 1'b0;
    end else if (w_write) begin
      r_par <= ^w_wsel;
    end
  end

  assign q_par = r_par;
`endif

  assign q    = r_q;
  assign nq   = ~r_q;
  assign gnt  = r_gnt;
  assign busy = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_shared_reg_arbiter.sv
// ============================================================================
//  Module   : tb_shared_reg_arbiter
//  Purpose  : Self-checking bench for shared_reg_arbiter. A transaction-level
//             reference model predicts gnt/q/nq/busy(/q_par) every cycle;
//             directed scenarios are followed by randomized requesters.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_shared_reg_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] wdata;
  logic [N-1:0]   gnt;
  logic [W-1:0]   q;
  logic [W-1:0]   nq;
  logic           busy;
`ifdef SHARED_REG_PARITY_EN
  logic           q_par;
`endif

  int checks = 0;
  int errors = 0;
  bit chk_en  = 1'b0;
  bit auto_drop = 1'b1;

  shared_reg_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .wdata (wdata),
    .gnt   (gnt),
    .q     (q),
    .nq    (nq),
    .busy  (busy)
`ifdef SHARED_REG_PARITY_EN
    ,
    .q_par (q_par)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  // m_last  : index granted most recently (lowest priority next time)
  // m_pend  : requester chosen at the last arbitration
  // m_left  : cycles remaining before the arbiter can arbitrate again
  int           m_last;
  int           m_pend;
  int           m_left;
  logic [N-1:0] m_gnt;
  logic [W-1:0] m_q;
  logic [W-1:0] m_nq;
  logic         m_par;
  logic         m_busy;

  function automatic int rr_next(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_last = N - 1; m_pend = -1; m_left = 0;
      m_gnt = '0; m_q = '0; m_nq = '1; m_par = 1'b0; m_busy = 1'b0;
    end else begin
      m_gnt = '0;
      if (m_left == 0) begin
        m_pend = rr_next(req, m_last);
        if (m_pend >= 0) m_left = 2;
      end else if (m_left == 2) begin
        if (req[m_pend]) begin
          m_q    = wdata[m_pend*W +: W];
          m_nq   = ~m_q;
          m_par  = ^m_q;
          m_gnt  = '0;
          m_gnt[m_pend] = 1'b1;
          m_last = m_pend;
          m_left = 1;
        end else begin
          m_left = 0;
        end
      end else begin
        m_left = 0;
      end
      m_busy = (m_left != 0);
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("gnt", 32'(gnt), 32'(m_gnt));
      chk("q", 32'(q), 32'(m_q));
      chk("nq", 32'(nq), 32'(m_nq));
      chk("busy", 32'(busy), 32'(m_busy));
`ifdef SHARED_REG_PARITY_EN
      chk("q_par", 32'(q_par), 32'(m_par));
`endif
    end
  end

  // Advance n cycles; granted requesters drop req after seeing gnt.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (auto_drop) req = req & ~m_gnt;
    end
  endtask

  task automatic set_data(input int idx, input logic [W-1:0] d);
    wdata[idx*W +: W] = d;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_nq", 32'(nq), 32'hFF);
    chk("rst_busy", 32'(busy), 32'h0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Single write: requester 2, data A5.
    set_data(2, 8'hA5);
    req = 4'b0100;
    step(2);
    chk("single_gnt", 32'(gnt), 32'h4);
    chk("single_q", 32'(q), 32'hA5);
    chk("single_nq", 32'(nq), 32'h5A);
    step(4);

    // Rotation with all requests held.
    auto_drop = 1'b0;
    set_data(0, 8'h11); set_data(1, 8'h22); set_data(2, 8'h33); set_data(3, 8'h44);
    req = 4'b1111;
    step(15);
    req = '0;
    auto_drop = 1'b1;
    step(4);

    // Withdrawal: req[1] only for the IDLE sample cycle.
    set_data(1, 8'h5C);
    req = 4'b0010;
    step(1);
    req = '0;
    step(3);
    chk("withdraw_q", 32'(q), 32'(m_q));
    req = 4'b0011;
    step(8);

    // Late arrival during RELEASE of a grant to requester 1.
    set_data(1, 8'h6D); set_data(3, 8'hE7);
    req = 4'b0010;
    step(2);
    req[3] = 1'b1;
    step(6);

`ifdef SHARED_REG_PARITY_EN
    set_data(0, 8'h07);
    req = 4'b0001;
    step(2);
    chk("par_07", 32'(q_par), 32'h1);
    step(2);
    set_data(0, 8'h03);
    req = 4'b0001;
    step(2);
    chk("par_03", 32'(q_par), 32'h0);
    step(2);
`endif

    // Asynchronous reset in RELEASE while gnt is high.
    set_data(0, 8'h9B);
    req = 4'b0001;
    step(2);
    chk("pre_rst_gnt", 32'(gnt), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_gnt", 32'(gnt), 32'h0);
    chk("arst_q", 32'(q), 32'h0);
    chk("arst_nq", 32'(nq), 32'hFF);
    chk("arst_busy", 32'(busy), 32'h0);
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized requesters: raise with fresh data, drop after grant,
    // occasionally withdraw early.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (req[i] && m_gnt[i]) begin
          req[i] = 1'b0;
        end else if (req[i] && ($urandom % 40 == 0)) begin
          req[i] = 1'b0;
        end else if (!req[i] && ($urandom % 4 == 0)) begin
          set_data(i, W'($urandom));
          req[i] = 1'b1;
        end
      end
    end

    req = '0;
    step(4);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
